// File: rtl/mux_tt_sequencer_if.sv
// Run-control and result bundle between a requester and the truth-table sequencer.
// The requester drives start/abort/expected. The sequencer returns status and the captured table.
interface mux_tt_sequencer_if;
  logic       start;
  logic       abort;
  logic [7:0] expected;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       match;
  logic [3:0] mismatch_count;

  modport master (
    output start, abort, expected,
    input  busy, done, result, match, mismatch_count
  );

  modport slave (
    input  start, abort, expected,
    output busy, done, result, match, mismatch_count
  );
endinterface

// File: rtl/mux_tt_sequencer.sv
// Truth-table self-check for a 3-input combinational block.
// The sequencer walks {a,b,c} through all eight vectors and holds each one for
// SETTLE_CYCLES cycles before sampling s. It builds the table from those samples
// and grades it against the expected table.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; {a,b,c}=0
// SETTLE | current vector applied, counting settle cycles
// SAMPLE | capture s into result[idx], advance or finish
// DONE   | one cycle: pulse done, grade result against expected
module mux_tt_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  mux_tt_sequencer_if.slave   ctl,
  input  logic                s,
  output logic                a,
  output logic                b,
  output logic                c
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // The counter counts up from 0. When it reaches CNT_LAST, the vector has been held long enough.
  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] result_q, result_d;
  logic       match_q, match_d;
  logic [3:0] mismatch_count_q, mismatch_count_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] sum;
    sum = 4'd0;
    for (int i = 0; i < 8; i++) begin
      sum = sum + 4'(v[i]);
    end
    return sum;
  endfunction

  // Next-state and datapath updates. Abort takes priority over a sample, including the last one.
  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    cnt_d            = cnt_q;
    result_d         = result_q;
    match_d          = match_q;
    mismatch_count_d = mismatch_count_q;
    done_d           = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ctl.start) begin
          idx_d            = 3'd0;
          cnt_d            = 4'd0;
          result_d         = 8'h00;
          match_d          = 1'b0;
          mismatch_count_d = 4'd0;
          state_d          = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (ctl.abort) begin
          idx_d   = 3'd0;
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == CNT_LAST) begin
            state_d = ST_SAMPLE;
          end
        end
      end

      ST_SAMPLE: begin
        if (ctl.abort) begin
          idx_d   = 3'd0;
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
        end else begin
          result_d[idx_q] = s;
          if (idx_q == 3'd7) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 3'd1;
            cnt_d   = 4'd0;
            state_d = ST_SETTLE;
          end
        end
      end

      ST_DONE: begin
        done_d           = 1'b1;
        match_d          = (result_q == ctl.expected);
        mismatch_count_d = popcount8(result_q ^ ctl.expected);
        idx_d            = 3'd0;
        state_d          = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        idx_d   = 3'd0;
      end
    endcase

    busy_d = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      idx_q            <= 3'd0;
      cnt_q            <= 4'd0;
      result_q         <= 8'h00;
      match_q          <= 1'b0;
      mismatch_count_q <= 4'd0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      cnt_q            <= cnt_d;
      result_q         <= result_d;
      match_q          <= match_d;
      mismatch_count_q <= mismatch_count_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
    end
  end

  assign a = idx_q[2];
  assign b = idx_q[1];
  assign c = idx_q[0];

  assign ctl.busy           = busy_q;
  assign ctl.done           = done_q;
  assign ctl.result         = result_q;
  assign ctl.match          = match_q;
  assign ctl.mismatch_count = mismatch_count_q;

endmodule

// File: tb/tb_mux_tt_sequencer.sv
// Scoreboard bench for mux_tt_sequencer: two instances (settle 2 and settle 1).
// Each instance drives a lookup-table model of the unit under test.
module tb_mux_tt_sequencer;

  typedef struct {
    logic [7:0] res;
    logic       m;
    logic [3:0] mc;
    int         done_at;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       a0, b0, c0, s0;
  logic       a1, b1, c1, s1;
  logic [7:0] tt0, tt1;

  int checks   = 0;
  int failures = 0;
  int edge_cnt = 0;
  int done_seen0 = 0;

  exp_t q0[$];
  exp_t q1[$];

  mux_tt_sequencer_if if0 ();
  mux_tt_sequencer_if if1 ();

  assign s0 = tt0[{a0, b0, c0}];
  assign s1 = tt1[{a1, b1, c1}];

  mux_tt_sequencer #(.SETTLE_CYCLES(2)) u0 (
    .clk(clk), .rst_n(rst_n), .ctl(if0), .s(s0), .a(a0), .b(b0), .c(c0)
  );

  mux_tt_sequencer #(.SETTLE_CYCLES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .ctl(if1), .s(s1), .a(a1), .b(b1), .c(c1)
  );

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (edge %0d)", nm, act, exp, edge_cnt);
    end
  endtask

  // Reference: the captured word is the unit's truth table, graded by equality and popcount.
  // done follows the accepting edge by eight (settle+sample) periods plus the DONE cycle.
  function automatic exp_t predict(input logic [7:0] tt, input logic [7:0] ev,
                                   input int acc, input int sc);
    exp_t e;
    e.res = 8'h00;
    for (int i = 0; i < 8; i++) e.res[i] = tt[i];
    e.m       = (e.res == ev);
    e.mc      = 4'($countones(e.res ^ ev));
    e.done_at = acc + 8 * (sc + 1) + 1;
    return e;
  endfunction

  // Monitor for instance 0: grade every done pulse against the scoreboard head
  always @(negedge clk) begin : mon0
    exp_t e;
    if (if0.done === 1'b1) begin
      done_seen0++;
      if (q0.size() == 0) begin
        chk("unexpected_done0", 32'd1, 32'd0);
      end else begin
        e = q0.pop_front();
        chk("done_at0", edge_cnt, e.done_at);
        chk("result0", if0.result, e.res);
        chk("match0", if0.match, e.m);
        chk("mismatch_count0", if0.mismatch_count, e.mc);
        chk("busy_in_done0", if0.busy, 0);
        chk("abc_in_done0", {a0, b0, c0}, 0);
      end
    end else if (q0.size() > 0 && edge_cnt > q0[0].done_at) begin
      chk("done_timeout0", edge_cnt, q0[0].done_at);
      void'(q0.pop_front());
    end
  end

  // Monitor for instance 1
  always @(negedge clk) begin : mon1
    exp_t e;
    if (if1.done === 1'b1) begin
      if (q1.size() == 0) begin
        chk("unexpected_done1", 32'd1, 32'd0);
      end else begin
        e = q1.pop_front();
        chk("done_at1", edge_cnt, e.done_at);
        chk("result1", if1.result, e.res);
        chk("match1", if1.match, e.m);
        chk("mismatch_count1", if1.mismatch_count, e.mc);
        chk("busy_in_done1", if1.busy, 0);
      end
    end else if (q1.size() > 0 && edge_cnt > q1[0].done_at) begin
      chk("done_timeout1", edge_cnt, q1[0].done_at);
      void'(q1.pop_front());
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_zero0(input string tag);
    chk({tag, "_abc"}, {a0, b0, c0}, 0);
    chk({tag, "_busy"}, if0.busy, 0);
    chk({tag, "_done"}, if0.done, 0);
    chk({tag, "_result"}, if0.result, 0);
    chk({tag, "_match"}, if0.match, 0);
    chk({tag, "_mmc"}, if0.mismatch_count, 0);
  endtask

  task automatic run0(input logic [7:0] tt, input logic [7:0] ev, input int wait_n);
    tt0 = tt;
    if0.expected = ev;
    if0.start = 1'b1;
    q0.push_back(predict(tt, ev, edge_cnt + 1, 2));
    cyc(1);
    if0.start = 1'b0;
    cyc(wait_n);
    chk("result_hold0", if0.result, tt);
  endtask

  initial begin : global_timeout
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    logic [7:0] tt, ev;
    int acc, seen;

    rst_n = 1'b0;
    tt0 = 8'h00; tt1 = 8'h00;
    if0.start = 1'b1; if0.abort = 1'b0; if0.expected = 8'h00;
    if1.start = 1'b1; if1.abort = 1'b0; if1.expected = 8'h00;

    // Reset held for two edges while start is high
    cyc(2);
    chk_zero0("reset");
    chk("reset_busy1", if1.busy, 0);
    rst_n = 1'b1;
    if0.start = 1'b0;
    if1.start = 1'b0;
    cyc(2);
    chk("no_run_after_reset", if0.busy, 0);

    // Nominal pass: XNOR(a,c) against A5, checking the vector walk
    tt0 = 8'hA5;
    if0.expected = 8'hA5;
    if0.start = 1'b1;
    q0.push_back(predict(8'hA5, 8'hA5, edge_cnt + 1, 2));
    cyc(1);
    if0.start = 1'b0;
    for (int j = 0; j < 25; j++) begin
      chk("vector_walk", {a0, b0, c0}, (j / 3 > 7) ? 7 : j / 3);
      if (j < 24) chk("busy_in_run", if0.busy, 1);
      cyc(1);
    end
    cyc(3);

    // Nominal fail: a&b against A5
    run0(8'hC0, 8'hA5, 28);

    // Start held high through two runs: one done per 26 cycles
    tt = 8'($urandom);
    ev = 8'($urandom);
    tt0 = tt;
    if0.expected = ev;
    if0.start = 1'b1;
    q0.push_back(predict(tt, ev, edge_cnt + 1, 2));
    q0.push_back(predict(tt, ev, edge_cnt + 27, 2));
    cyc(52);
    if0.start = 1'b0;
    cyc(5);
    chk("held_start_idle", if0.busy, 0);

    // Randomized runs
    for (int k = 0; k < 6; k++) begin
      tt = 8'($urandom);
      ev = ($urandom_range(0, 1) == 1) ? tt : 8'($urandom);
      cyc($urandom_range(0, 3));
      run0(tt, ev, 27);
    end

    // Abort while {a,b,c}=3'b011
    tt = 8'($urandom);
    tt0 = tt;
    if0.expected = 8'($urandom);
    seen = done_seen0;
    if0.start = 1'b1;
    cyc(1);
    if0.start = 1'b0;
    acc = edge_cnt;
    cyc(9);
    chk("abort_at_vec3", {a0, b0, c0}, 3);
    if0.abort = 1'b1;
    cyc(1);
    if0.abort = 1'b0;
    chk("abort_busy", if0.busy, 0);
    chk("abort_abc", {a0, b0, c0}, 0);
    chk("abort_result", if0.result, tt & 8'h07);
    chk("abort_match", if0.match, 0);
    chk("abort_mmc", if0.mismatch_count, 0);
    cyc(30);
    chk("abort_no_done", done_seen0, seen);
    chk("abort_run_len", edge_cnt - acc, 40);

    // Reset at edge 10 of a run, then a fresh XNOR run
    tt0 = 8'hA5;
    if0.expected = 8'hA5;
    if0.start = 1'b1;
    q0.push_back(predict(8'hA5, 8'hA5, edge_cnt + 1, 2));
    cyc(1);
    if0.start = 1'b0;
    cyc(9);
    rst_n = 1'b0;
    q0.delete();
    cyc(1);
    rst_n = 1'b1;
    chk_zero0("midreset");
    run0(8'hA5, 8'hA5, 28);

    // Settle of one cycle
    tt1 = 8'hA5;
    if1.expected = 8'hA5;
    if1.start = 1'b1;
    q1.push_back(predict(8'hA5, 8'hA5, edge_cnt + 1, 1));
    cyc(1);
    if1.start = 1'b0;
    cyc(20);
    chk("result_hold1", if1.result, 8'hA5);

    cyc(2);
    chk("queue0_drained", q0.size(), 0);
    chk("queue1_drained", q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
